add_seq_ctrl: RTL and testbench

- Sequencing controller that adds two WIDTH-bit operands nibble-serially through one shared 4-bit adder slice, one nibble per clock, LSB nibble first.
- Holds the ripple carry between nibbles in a register.
- Valid/ready handshakes on both input and output sides.
- Sits between operand producers and consumers wherever area matters more than latency.

---
 rtl/add_seq_pkg.sv | 29 ++
 rtl/add_seq_ctrl_add4.sv | 29 ++
 rtl/add_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_add_seq_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// -----------------------------------------------------------------------------
// add_seq_pkg
// Shared definitions for the nibble-serial adder controller (add_seq_ctrl).
//   state_e  : controller state encoding (IDLE, RUN, DONE), 2 bits
//   NIBBLE_W : width of the shared adder slice in bits
//   clog2()  : width of the nibble counter for a given nibble count
// -----------------------------------------------------------------------------
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

    // Never returns less than 1 so a single-nibble build still has a legal
    // (if trivially small) counter register.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_add4.sv
// -----------------------------------------------------------------------------
// add4
// Plain 4-bit ripple-carry adder used as the shared nibble slice.
//   a, b : 4-bit addends
//   cin  : carry into bit 0
//   sum  : 4-bit sum
//   cout : carry out of bit 3
// -----------------------------------------------------------------------------
module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    // Ripple the carry bit by bit through a local variable.
    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl
// Adds two WIDTH-bit operands one nibble per clock through a single shared
// 4-bit adder slice, LSB nibble first, holding the ripple carry in a register
// between nibbles. Valid/ready handshakes on both sides.
//
// Optional feature macro: ADD_SEQ_SUB_EN
//   When defined, adds port in_sub; with in_sub=1 the controller computes
//   in_a - in_b (B inverted into the slice, carry forced to 1 at load, in_cin
//   ignored). out_cout=1 then means "no borrow".
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake
//   in_a, in_b, in_cin   : operands and carry-in to nibble 0
//   in_sub               : subtract select (ADD_SEQ_SUB_EN only)
//   out_valid / out_ready: result handshake
//   out_sum, out_cout    : sum and carry out of the MSB nibble
//   out_ovf              : two's-complement overflow
// -----------------------------------------------------------------------------
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = clog2(NIB);

    generate
        if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
            $error("add_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               carry_q, carry_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               sub_active;

`ifdef ADD_SEQ_SUB_EN
    logic               sub_q, sub_d;
    assign sub_active = sub_q;
`else
    assign sub_active = 1'b0;
`endif

    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic [WIDTH+3:0]    s_shift;
    logic                ovf_raw;

    // Subtraction feeds the inverted B nibble; the +1 comes from the carry
    // register being loaded with 1 at acceptance.
    assign slice_b = b_q[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_active}};

    add4 u_slice (
        .a    (a_q[NIBBLE_W-1:0]),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // New nibble enters at the top while the sum register shifts right, so
    // after NIB steps the first nibble has arrived at the bottom. Building the
    // shift from a wider concatenation keeps WIDTH=4 legal.
    assign s_shift = {slice_sum, s_q};

    // Next-state and datapath update. Everything holds by default; only the
    // acceptance edge in IDLE and each RUN cycle move the registers.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
`ifdef ADD_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    count_d = '0;
                    a_msb_d = in_a[WIDTH-1];
                    b_msb_d = in_b[WIDTH-1];
`ifdef ADD_SEQ_SUB_EN
                    sub_d   = in_sub;
                    carry_d = in_sub ? 1'b1 : in_cin;
`else
                    carry_d = in_cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d     = s_shift[WIDTH+3:NIBBLE_W];
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                carry_d = slice_cout;
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(NIB - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register bank with synchronous active-low reset; a reset in any state
    // discards whatever partial result was in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
`ifdef ADD_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // Overflow uses the captured operand sign bits, since A and B have been
    // shifted away by the time the result is presented. For subtraction the
    // effective B sign is inverted, which flips the sign-match test.
    always_comb begin
        ovf_raw = 1'b0;
        if (sub_active) begin
            ovf_raw = (a_msb_q != b_msb_q) && (s_q[WIDTH-1] != a_msb_q);
        end else begin
            ovf_raw = (a_msb_q == b_msb_q) && (s_q[WIDTH-1] != a_msb_q);
        end
    end

    // Result outputs are only driven in DONE so the shifting partial sum is
    // never visible to the consumer.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_valid ? s_q : '0;
    assign out_cout  = out_valid & carry_q;
    assign out_ovf   = out_valid & ovf_raw;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_add_seq_ctrl
// Self-checking bench for add_seq_ctrl at WIDTH=16. Expected results come from
// an integer-arithmetic reference model of add/subtract with signed-range
// overflow detection.
// -----------------------------------------------------------------------------
module tb_add_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              in_cin;
`ifdef ADD_SEQ_SUB_EN
    logic              in_sub;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_sum;
    logic              out_cout;
    logic              out_ovf;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    add_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef ADD_SEQ_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance one clock and settle just after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: returns {ovf, cout, sum}. Add and subtract are evaluated as
    // whole-number arithmetic; overflow is "signed result out of range".
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        int ua, ub, sa, sb, ur, sr;
        logic [15:0] s;
        logic co, ov;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end else begin
            ur = ua + ub + int'(cin);
            sr = sa + sb + int'(cin);
            co = (ur > 65535);
        end
        s  = ur[15:0];
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, s};
    endfunction

    // Waits for in_ready, presents one operand set, then waits for out_valid
    // while scribbling on the inputs. Leaves the result handshake to the
    // caller. lat = cycles from acceptance edge to out_valid (-1 on timeout).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output logic [15:0] sum, output logic cout, output logic ovf,
                         output int lat, output int acc_cyc);
        int guard;
        guard   = 0;
        acc_cyc = -1;
        sum     = '0;
        cout    = 1'b0;
        ovf     = 1'b0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            lat = -1;
            return;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            in_cin   = 1'($urandom);
            in_valid = 1'($urandom);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            lat = -1;
            return;
        end
        sum  = out_sum;
        cout = out_cout;
        ovf  = out_ovf;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_in_ready got %b expected 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_valid got %b expected 0", out_valid); end
        vectors++;
        if (out_sum !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_out_sum got %h expected 0000", out_sum); end
        vectors++;
        if (out_cout !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_cout got %b expected 0", out_cout); end
        vectors++;
        if (out_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_ovf got %b expected 0", out_ovf); end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_in_ready got %b expected 1", in_ready); end
    endtask

    task automatic test_directed;
        logic [15:0] ta [3];
        logic [15:0] tb [3];
        logic [15:0] sum;
        logic cout, ovf;
        logic [17:0] exp;
        int lat, acc;
        ta[0] = 16'h1234; tb[0] = 16'h1111;
        ta[1] = 16'hFFFF; tb[1] = 16'h0001;
        ta[2] = 16'h7FFF; tb[2] = 16'h0001;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(ta[i], tb[i], 1'b0, sum, cout, ovf, lat, acc);
            exp = model(ta[i], tb[i], 1'b0, 1'b0);
            vectors++;
            if (lat !== NIB) begin miscompares++; $display("[TB] FAIL dir_latency #%0d got %0d expected %0d", i, lat, NIB); end
            vectors++;
            if (sum !== exp[15:0]) begin miscompares++; $display("[TB] FAIL dir_sum #%0d got %h expected %h", i, sum, exp[15:0]); end
            vectors++;
            if (cout !== exp[16]) begin miscompares++; $display("[TB] FAIL dir_cout #%0d got %b expected %b", i, cout, exp[16]); end
            vectors++;
            if (ovf !== exp[17]) begin miscompares++; $display("[TB] FAIL dir_ovf #%0d got %b expected %b", i, ovf, exp[17]); end
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL dir_busy #%0d in_ready got %b expected 0", i, in_ready); end
            tick();
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL dir_turnaround #%0d in_ready/out_valid got %b/%b expected 1/0", i, in_ready, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [15:0] sum;
        logic cout, ovf;
        int lat, acc;
        out_ready = 1'b0;
        do_op(16'h00FF, 16'h0F01, 1'b0, sum, cout, ovf, lat, acc);
        vectors++;
        if (lat !== NIB) begin miscompares++; $display("[TB] FAIL bp_latency got %0d expected %0d", lat, NIB); end
        vectors++;
        if (sum !== 16'h1000) begin miscompares++; $display("[TB] FAIL bp_sum got %h expected 1000", sum); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            in_cin   = 1'($urandom);
            tick();
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || out_sum !== 16'h1000 || out_cout !== cout || out_ovf !== ovf || in_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_hold cycle %0d valid/sum/cout/ovf/in_ready got %b/%h/%b/%b/%b expected 1/1000/%b/%b/0",
                         i, out_valid, out_sum, out_cout, out_ovf, in_ready, cout, ovf);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_release in_ready/out_valid got %b/%b expected 1/0", in_ready, out_valid);
        end
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_idle in_ready got %b expected 1", in_ready); end
    endtask

    task automatic test_reset_mid_op;
        logic [15:0] sum;
        logic cout, ovf;
        int lat, acc;
        logic seen_valid;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'hAAAA;
        in_b      = 16'h5555;
        in_cin    = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL midrst_state valid/in_ready/sum got %b/%b/%h expected 0/1/0000", out_valid, in_ready, out_sum);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        vectors++;
        if (seen_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_discard out_valid seen %b expected 0", seen_valid); end
        do_op(16'h0F0F, 16'h00F1, 1'b1, sum, cout, ovf, lat, acc);
        vectors++;
        if (lat !== NIB) begin miscompares++; $display("[TB] FAIL midrst_latency got %0d expected %0d", lat, NIB); end
        vectors++;
        if (sum !== 16'h1001) begin miscompares++; $display("[TB] FAIL midrst_sum got %h expected 1001", sum); end
        vectors++;
        if (cout !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_cout got %b expected 0", cout); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [15:0] a, b, sum;
        logic cin, sub, cout, ovf;
        logic [17:0] exp;
        int lat, acc, stall;
        for (int i = 0; i < 24; i++) begin
            a     = 16'($urandom);
            b     = 16'($urandom);
            if (i % 6 == 0) a = 16'h8000;
            if (i % 6 == 1) b = 16'h7FFF;
            cin   = 1'($urandom);
            sub   = 1'b0;
`ifdef ADD_SEQ_SUB_EN
            sub    = 1'($urandom);
            in_sub = sub;
`endif
            stall = $urandom_range(0, 3);
            out_ready = 1'b0;
            do_op(a, b, cin, sum, cout, ovf, lat, acc);
            exp = model(a, b, cin, sub);
            vectors++;
            if (lat !== NIB) begin miscompares++; $display("[TB] FAIL rnd_latency a=%h b=%h got %0d expected %0d", a, b, lat, NIB); end
            vectors++;
            if ({ovf, cout, sum} !== exp) begin
                miscompares++;
                $display("[TB] FAIL rnd_result a=%h b=%h cin=%b sub=%b got ovf/cout/sum %b/%b/%h expected %b/%b/%h",
                         a, b, cin, sub, ovf, cout, sum, exp[17], exp[16], exp[15:0]);
            end
            for (int s = 0; s < stall; s++) tick();
            vectors++;
            if (out_valid !== 1'b1 || out_sum !== exp[15:0]) begin
                miscompares++;
                $display("[TB] FAIL rnd_stall a=%h b=%h valid/sum got %b/%h expected 1/%h", a, b, out_valid, out_sum, exp[15:0]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
`ifdef ADD_SEQ_SUB_EN
        in_sub = 1'b0;
`endif
    endtask

    task automatic test_back_to_back;
        logic [15:0] sum0, sum1;
        logic c0, c1, o0, o1;
        int lat0, lat1, acc0, acc1;
        logic [17:0] e0, e1;
        out_ready = 1'b1;
        do_op(16'h4321, 16'h2222, 1'b1, sum0, c0, o0, lat0, acc0);
        do_op(16'hF00D, 16'h1FF3, 1'b0, sum1, c1, o1, lat1, acc1);
        e0 = model(16'h4321, 16'h2222, 1'b1, 1'b0);
        e1 = model(16'hF00D, 16'h1FF3, 1'b0, 1'b0);
        vectors++;
        if ({o0, c0, sum0} !== e0) begin miscompares++; $display("[TB] FAIL b2b_first got %b/%b/%h expected %b/%b/%h", o0, c0, sum0, e0[17], e0[16], e0[15:0]); end
        vectors++;
        if ({o1, c1, sum1} !== e1) begin miscompares++; $display("[TB] FAIL b2b_second got %b/%b/%h expected %b/%b/%h", o1, c1, sum1, e1[17], e1[16], e1[15:0]); end
        vectors++;
        if (acc1 - acc0 !== NIB + 2) begin miscompares++; $display("[TB] FAIL b2b_spacing got %0d expected %0d", acc1 - acc0, NIB + 2); end
        tick();
        out_ready = 1'b0;
    endtask

`ifdef ADD_SEQ_SUB_EN
    task automatic test_sub;
        logic [15:0] ta [2];
        logic [15:0] tb [2];
        logic [15:0] exp_s [2];
        logic exp_c [2];
        logic exp_o [2];
        logic [15:0] sum;
        logic cout, ovf;
        int lat, acc;
        ta[0] = 16'h0005; tb[0] = 16'h0007; exp_s[0] = 16'hFFFE; exp_c[0] = 1'b0; exp_o[0] = 1'b0;
        ta[1] = 16'h8000; tb[1] = 16'h0001; exp_s[1] = 16'h7FFF; exp_c[1] = 1'b1; exp_o[1] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_sub = 1'b1;
            do_op(ta[i], tb[i], 1'($urandom), sum, cout, ovf, lat, acc);
            vectors++;
            if (sum !== exp_s[i] || cout !== exp_c[i] || ovf !== exp_o[i]) begin
                miscompares++;
                $display("[TB] FAIL sub #%0d got sum/cout/ovf %h/%b/%b expected %h/%b/%b", i, sum, cout, ovf, exp_s[i], exp_c[i], exp_o[i]);
            end
            tick();
        end
        in_sub    = 1'b0;
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        in_sub    = 1'b0;
`endif
        $display("[TB] starting add_seq_ctrl bench, WIDTH=%0d", WIDTH);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
`ifdef ADD_SEQ_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
